// File: rtl/serial_tx.sv
// serial_tx: 9-bit serial transmitter.
// Frame = start bit (0), 9 data bits LSB first, stop bit (1); each bit lasts
// clk_divisor clocks (0 means 256). Words are queued through a write strobe.
// Optional feature macro: SERIAL_TX_FIFO_EN. When defined, the word buffer is a
// circular FIFO of 2**FIFO_AW entries. Otherwise it is a single holding
// register and FIFO_AW is unused.
module serial_tx #(
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] clk_divisor,
  input  logic [8:0] data,
  input  logic       send,
  output logic       ready,
  output logic       tx,
  output logic       idle,
  output logic       overflow
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]  state;
  logic [10:0] shift_reg;
  logic [3:0]  bit_cnt;
  logic [7:0]  div_reg;
  logic [7:0]  div_cnt;

  logic        buf_full;
  logic        buf_empty;
  logic [8:0]  buf_head;
  logic        push;
  logic        pop;
  logic        bit_end;
  logic        frame_end;

  // A word is accepted only if there is room; otherwise it is dropped.
  assign push      = send && !buf_full;
  // Down-counter terminal count is 1, so a loaded value of D gives D clocks
  // per bit and a loaded 0 wraps through 255 for 256 clocks.
  assign bit_end   = (state == ST_DATA) && (div_cnt == 8'd1);
  assign frame_end = bit_end && (bit_cnt == 4'd0);
  // A frame is loaded from the buffer when idle or right as a stop bit ends,
  // which makes back-to-back frames contiguous.
  assign pop       = !buf_empty && ((state == ST_IDLE) || frame_end);

`ifdef SERIAL_TX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  // Depth is a power of two, so count == DEPTH is exactly the MSB being set.
  assign buf_full  = count[FIFO_AW];
  assign buf_empty = (count == '0);
  assign buf_head  = mem[rd_ptr];

  // Store accepted words at the write pointer.
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [8:0] hold;
  logic       hold_valid;

  assign buf_full  = hold_valid;
  assign buf_empty = !hold_valid;
  assign buf_head  = hold;

  // Single holding register; push needs it empty and pop needs it full, so
  // the two never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Frame sequencer: load, bit timing and shifting of the outgoing frame.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '1;
      bit_cnt   <= '0;
      div_reg   <= '0;
      div_cnt   <= '0;
    end else if (pop) begin
      shift_reg <= {1'b1, buf_head, 1'b0};
      div_reg   <= clk_divisor;
      div_cnt   <= clk_divisor;
      bit_cnt   <= 4'd10;
      state     <= ST_DATA;
    end else if (state == ST_DATA) begin
      if (bit_end) begin
        if (bit_cnt == 4'd0) begin
          state     <= ST_IDLE;
          shift_reg <= '1;
        end else begin
          shift_reg <= {1'b1, shift_reg[10:1]};
          bit_cnt   <= bit_cnt - 1'b1;
          div_cnt   <= div_reg;
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

  // Sticky flag for a strobe that arrived while the buffer was full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  overflow <= 1'b0;
    else if (send && buf_full) overflow <= 1'b1;
  end

  // The shift register idles at all ones, so its LSB is the registered line.
  assign tx    = shift_reg[0];
  assign ready = !buf_full;
  assign idle  = (state == ST_IDLE) && buf_empty;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx.
// A loopback receiver decodes the line using the bit period expected for each
// frame and compares against a queue of words the bench has sent. Works for
// both builds (SERIAL_TX_FIFO_EN defined or not).
module tb_serial_tx;

`ifdef SERIAL_TX_FIFO_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  typedef struct {
    logic [8:0] word;
    int         div;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [7:0] clk_divisor;
  logic [8:0] data;
  logic       send;
  logic       ready;
  logic       tx;
  logic       idle;
  logic       overflow;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     rx_count = 0;
  int     cyc = 0;

  serial_tx #(.FIFO_AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_divisor (clk_divisor),
    .data        (data),
    .send        (send),
    .ready       (ready),
    .tx          (tx),
    .idle        (idle),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Loopback receiver: samples every clock of every bit and requires the
  // level to be constant for exactly the expected bit period.
  initial begin : rx_monitor
    int         d;
    bit         aborted;
    bit         stable;
    logic [10:0] bits;
    forever begin
      @(negedge clk);
      if (rst || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        while (tx === 1'b0 && !rst) @(negedge clk);
        continue;
      end
      d       = exp_q[0].div;
      aborted = 1'b0;
      stable  = 1'b1;
      bits    = '0;
      for (int b = 0; b < 11 && !aborted; b++) begin
        for (int s = 0; s < d && !aborted; s++) begin
          if (b != 0 || s != 0) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted) begin
            if (s == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
      end
      if (!aborted) begin
        check("rx_start_bit", 32'(bits[0]), 0);
        check("rx_stop_bit", 32'(bits[10]), 1);
        check("rx_bit_timing", 32'(stable), 1);
        check("rx_word", 32'(bits[9:1]), 32'(exp_q[0].word));
        void'(exp_q.pop_front());
        rx_count++;
      end
    end
  end

  // Called at a negedge: waits for ready, strobes one word, returns at the
  // following negedge with send released.
  task automatic send_word(input logic [8:0] w, input int d);
    int n = 0;
    while (!ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    data = w;
    send = 1'b1;
    exp_q.push_back('{word: w, div: d});
    @(negedge clk);
    send = 1'b0;
  endtask

  // Sends into an empty, idle transmitter and checks the accept latency.
  task automatic start_frame(input logic [8:0] w, input int d, output int e0);
    send_word(w, d);
    e0 = cyc;
    check("accept_idle_low", 32'(idle), 0);
    check("accept_tx_high", 32'(tx), 1);
    check("accept_ready", 32'(ready), 32'(BUF_DEPTH > 1));
    @(negedge clk);
    check("start_bit_latency", 32'(tx), 0);
  endtask

  task automatic wait_drain(input int budget, output int done_cyc);
    int n = 0;
    while (!(exp_q.size() == 0 && idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    if (!(exp_q.size() == 0 && idle)) begin
      check("drain_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin : main
    int e0;
    int done_cyc;
    int rx_before;
    int low_cnt;
    logic [8:0] w;

    rst         = 1'b0;
    send        = 1'b0;
    data        = '0;
    clk_divisor = 8'd4;
    #2 rst = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 1);
    check("reset_ready", 32'(ready), 1);
    check("reset_idle", 32'(idle), 1);
    check("reset_overflow", 32'(overflow), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame, D = 4: 44 clocks of line activity.
    clk_divisor = 8'd4;
    start_frame(9'h1A5, 4, e0);
    wait_drain(200, done_cyc);
    check("single_idle_rise", 32'(done_cyc - e0), 45);

    // Back-to-back frames, D = 3: no gap, 66 clocks of activity.
    repeat (3) @(negedge clk);
    clk_divisor = 8'd3;
    start_frame(9'h000, 3, e0);
    send_word(9'h1FF, 3);
    wait_drain(300, done_cyc);
    check("b2b_idle_rise", 32'(done_cyc - e0), 67);

    // Divisor change mid-frame: current frame stays at 8, next runs at 2.
    repeat (3) @(negedge clk);
    clk_divisor = 8'd8;
    start_frame(9'h0C3, 8, e0);
    send_word(9'h13C, 2);
    repeat (20) @(negedge clk);
    clk_divisor = 8'd2;
    wait_drain(400, done_cyc);
    check("divchg_idle_rise", 32'(done_cyc - e0), 1 + 88 + 22);

    // Divisor 0 means 256 clocks per bit.
    repeat (3) @(negedge clk);
    clk_divisor = 8'd0;
    start_frame(9'h0A7, 256, e0);
    wait_drain(3000, done_cyc);
    check("div256_idle_rise", 32'(done_cyc - e0), 1 + 11 * 256);

    // Overflow: fill every free slot during a frame, then one more strobe.
    repeat (3) @(negedge clk);
    clk_divisor = 8'd4;
    rx_before = rx_count;
    start_frame(9'h111, 4, e0);
    for (int i = 0; i < BUF_DEPTH; i++) send_word(9'(i * 37 + 5), 4);
    check("full_ready_low", 32'(ready), 0);
    check("full_no_overflow", 32'(overflow), 0);
    data = 9'h0EE;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("overflow_set", 32'(overflow), 1);
    check("overflow_ready_low", 32'(ready), 0);
    wait_drain(1000, done_cyc);
    check("overflow_sticky", 32'(overflow), 1);
    check("overflow_rx_count", 32'(rx_count - rx_before), 32'(1 + BUF_DEPTH));

    // Reset in the middle of data bit 4, with another word queued.
    repeat (3) @(negedge clk);
    clk_divisor = 8'd8;
    start_frame(9'h155, 8, e0);
    send_word(9'h0AA, 8);
    repeat (42) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_ready", 32'(ready), 1);
    check("midrst_idle", 32'(idle), 1);
    check("midrst_overflow", 32'(overflow), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    low_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("post_rst_tx_quiet", 32'(low_cnt), 0);
    check("post_rst_idle", 32'(idle), 1);

    // Random stream with random gaps; exercises pointer wraparound.
    clk_divisor = 8'($urandom_range(1, 4));
    rx_before   = rx_count;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 9'($urandom_range(0, 511));
      send_word(w, int'(clk_divisor));
    end
    wait_drain(4000, done_cyc);
    check("stream_rx_count", 32'(rx_count - rx_before), 20);
    check("stream_no_overflow", 32'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
